sprite_painter: RTL and testbench

Per-frame sprite rasteriser feeding the SRAM controller's program write port (program_x / program_y / program_data). On each frame_clk rising edge it walks a sprite table, fetches each valid sprite's 32x32 bitmap from sprite ROM and presents one pixel at a time, holding each for HOLD sram_clk cycles so the controller's two write slots per 4-cycle round capture it. Transparent and off-screen pixels, and idle time, are parked on an invisible address: x=0, y=PARK_Y.

---
 rtl/sprite_painter.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_painter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_painter.sv
// sprite_painter
// Walks the sprite table once per frame, fetches each valid sprite's 32x32
// bitmap from sprite ROM and presents one pixel at a time on the SRAM
// controller's program port. Each pixel is held for HOLD cycles. Transparent,
// off-screen and idle writes are parked at x=0, y=PARK_Y.
module sprite_painter #(
  parameter int          NUM_SPRITES = 16,
  parameter int          HOLD        = 4,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter logic [8:0]  PARK_Y      = 9'd511,
  localparam int         IW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic          i_sram_clk,
  input  logic          i_reset_n,
  input  logic          i_frame_clk,
  output logic [IW-1:0] o_sprite_index,
  input  logic          i_sprite_valid,
  input  logic [9:0]    i_sprite_x,
  input  logic [9:0]    i_sprite_y,
  input  logic [3:0]    i_sprite_id,
  output logic [13:0]   o_rom_addr,
  input  logic [15:0]   i_rom_data,
  output logic [9:0]    o_program_x,
  output logic [9:0]    o_program_y,
  output logic [15:0]   o_program_data,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_overrun
);

  localparam int            PW       = $clog2(HOLD);
  localparam logic [PW-1:0] PH_LAST  = PW'(HOLD - 1);
  // rom_data for the current rom_addr is valid during phase 1
  localparam logic [PW-1:0] PH_CAPT  = PW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_SPRITES - 1);
  localparam logic [9:0]    PARK_Y10 = {1'b0, PARK_Y};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPR_REQ,
    S_SPR_LOAD,
    S_PIXEL,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic           r_frame_clk_d;
  logic [IW-1:0]  r_sprite_index;
  logic           r_busy;
  logic           r_frame_done;
  logic           r_overrun;
  logic [4:0]     r_row;
  logic [4:0]     r_col;
  logic [PW-1:0]  r_phase;
  logic [PW-1:0]  r_done_cnt;

  logic [9:0]     r_x;
  logic [9:0]     r_y;
  logic [3:0]     r_id;

  logic [9:0]     r_program_x;
  logic [9:0]     r_program_y;
  logic [15:0]    r_program_data;

  logic           w_start;
  logic           w_restart;
  logic           w_last_sprite;
  logic           w_pixel_step;
  logic           w_last_pixel;
  logic           w_skip_sprite;
  logic           w_next_sprite;
  logic           w_done_end;
  logic           w_capture;
  logic [10:0]    w_px;
  logic [10:0]    w_py;

  // A pixel is written only when on-screen and not the colour key.
  function automatic logic f_drawn(input logic [10:0] px,
                                   input logic [10:0] py,
                                   input logic [15:0] pix);
    return (px < 11'd640) && (py < 11'd480) && (pix != TRANSPARENT);
  endfunction

  assign w_start       = i_frame_clk & ~r_frame_clk_d;
  assign w_restart     = w_start && (r_state != S_IDLE);
  assign w_last_sprite = (r_sprite_index == IDX_LAST);
  assign w_pixel_step  = (r_state == S_PIXEL) && (r_phase == PH_LAST);
  assign w_last_pixel  = w_pixel_step && (r_row == 5'd31) && (r_col == 5'd31);
  assign w_skip_sprite = (r_state == S_SPR_LOAD) && !i_sprite_valid;
  assign w_next_sprite = (w_skip_sprite || w_last_pixel) && !w_last_sprite;
  assign w_done_end    = (r_state == S_DONE) && (r_done_cnt == PH_LAST);
  assign w_capture     = (r_state == S_PIXEL) && (r_phase == PH_CAPT);

  // 11-bit sums so that right/bottom overflow is visible to the clip test
  assign w_px = {1'b0, r_x} + {6'b0, r_col};
  assign w_py = {1'b0, r_y} + {6'b0, r_row};

  assign o_rom_addr     = {r_id, r_row, r_col};
  assign o_sprite_index = r_sprite_index;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;
  assign o_overrun      = r_overrun;
  assign o_program_x    = r_program_x;
  assign o_program_y    = r_program_y;
  assign o_program_data = r_program_data;

  // State register
  always_ff @(posedge i_sram_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; a frame edge while busy aborts and restarts the walk
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_SPR_REQ;
      S_SPR_REQ:  w_next = S_SPR_LOAD;
      S_SPR_LOAD: begin
        if (!i_sprite_valid) w_next = w_last_sprite ? S_DONE : S_SPR_REQ;
        else                 w_next = S_PIXEL;
      end
      S_PIXEL:    if (w_last_pixel) w_next = w_last_sprite ? S_DONE : S_SPR_REQ;
      S_DONE:     if (w_done_end) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_restart) w_next = S_SPR_REQ;
  end

  // Frame edge detector, sprite index, busy / done / overrun flags
  always_ff @(posedge i_sram_clk) begin
    if (!i_reset_n) begin
      r_frame_clk_d  <= 1'b1;
      r_sprite_index <= '0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_frame_clk_d <= i_frame_clk;
      r_frame_done  <= w_done_end && !w_start;
      if (w_restart) r_overrun <= 1'b1;
      if (w_start)            r_sprite_index <= '0;
      else if (w_next_sprite) r_sprite_index <= r_sprite_index + IW'(1);
      if (w_start)         r_busy <= 1'b1;
      else if (w_done_end) r_busy <= 1'b0;
    end
  end

  // Pixel walk counters: phase within a pixel, then column, then row
  always_ff @(posedge i_sram_clk) begin
    if (!i_reset_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_phase    <= '0;
      r_done_cnt <= '0;
    end else begin
      if (r_state == S_DONE) r_done_cnt <= r_done_cnt + PW'(1);
      else                   r_done_cnt <= '0;
      if (r_state == S_SPR_LOAD) begin
        r_row   <= '0;
        r_col   <= '0;
        r_phase <= '0;
      end else if (r_state == S_PIXEL) begin
        if (r_phase == PH_LAST) begin
          r_phase <= '0;
          r_col   <= r_col + 5'd1;
          if (r_col == 5'd31) r_row <= r_row + 5'd1;
        end else begin
          r_phase <= r_phase + PW'(1);
        end
      end
    end
  end

  // Sprite attributes, sampled the cycle after the table address was driven
  always_ff @(posedge i_sram_clk) begin
    if (r_state == S_SPR_LOAD) begin
      r_x  <= i_sprite_x;
      r_y  <= i_sprite_y;
      r_id <= i_sprite_id;
    end
  end

  // Program port: drawn or parked pixel at phase 1, parked again at frame end
  always_ff @(posedge i_sram_clk) begin
    if (!i_reset_n) begin
      r_program_x    <= '0;
      r_program_y    <= PARK_Y10;
      r_program_data <= '0;
    end else if (w_done_end && !w_start) begin
      r_program_x    <= '0;
      r_program_y    <= PARK_Y10;
      r_program_data <= '0;
    end else if (w_capture && !w_start) begin
      if (f_drawn(w_px, w_py, i_rom_data)) begin
        r_program_x    <= w_px[9:0];
        r_program_y    <= w_py[9:0];
        r_program_data <= i_rom_data;
      end else begin
        r_program_x    <= '0;
        r_program_y    <= PARK_Y10;
        r_program_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_painter.sv
// Directed bench for sprite_painter: table-driven frame checks plus
// hand-written reset and overrun sequences.
module tb_sprite_painter;

  localparam int IW = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          frame_clk;
  logic [IW-1:0] sprite_index;
  logic          sprite_valid;
  logic [9:0]    sprite_x;
  logic [9:0]    sprite_y;
  logic [3:0]    sprite_id;
  logic [13:0]   rom_addr;
  logic [15:0]   rom_data;
  logic [9:0]    program_x;
  logic [9:0]    program_y;
  logic [15:0]   program_data;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  sprite_painter dut (
    .i_sram_clk     (clk),
    .i_reset_n      (reset_n),
    .i_frame_clk    (frame_clk),
    .o_sprite_index (sprite_index),
    .i_sprite_valid (sprite_valid),
    .i_sprite_x     (sprite_x),
    .i_sprite_y     (sprite_y),
    .i_sprite_id    (sprite_id),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .o_program_x    (program_x),
    .o_program_y    (program_y),
    .o_program_data (program_data),
    .o_busy         (busy),
    .o_frame_done   (frame_done),
    .o_overrun      (overrun)
  );

  // Sprite table and ROM models, both with one cycle of read latency
  logic       t_valid [16];
  logic [9:0] t_x     [16];
  logic [9:0] t_y     [16];
  logic [3:0] t_id    [16];
  int         rom_mode;

  always @(posedge clk) begin
    sprite_valid <= t_valid[sprite_index];
    sprite_x     <= t_x[sprite_index];
    sprite_y     <= t_y[sprite_index];
    sprite_id    <= t_id[sprite_index];
    if (rom_mode == 1 && rom_addr[0] == 1'b0) rom_data <= 16'hF81F;
    else                                       rom_data <= {2'b00, rom_addr};
  end

  logic watch;
  logic fd_seen;
  always @(negedge clk) if (watch && frame_done === 1'b1) fd_seen = 1'b1;

  int n_vec;
  int n_bad;

  typedef struct {
    int         off;
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic [15:0] d;
    logic       b;
    logic       f;
    logic       o;
    logic [3:0] idx;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [42:0] pk(input logic [9:0] x, input logic [9:0] y,
                                     input logic [15:0] d, input logic b,
                                     input logic f, input logic o,
                                     input logic [3:0] idx);
    return {x, y, d, b, f, o, idx};
  endfunction

  function automatic logic [42:0] dut_pk();
    return pk(program_x, program_y, program_data, busy, frame_done, overrun, sprite_index);
  endfunction

  task automatic chk(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d d=%h b=%b fd=%b ov=%b idx=%0d, expected x=%0d y=%0d d=%h b=%b fd=%b ov=%b idx=%0d",
               name, act[42:33], act[32:23], act[22:7], act[6], act[5], act[4], act[3:0],
               exp[42:33], exp[32:23], exp[22:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input int off, input string name, input logic [9:0] x,
                     input logic [9:0] y, input logic [15:0] d, input logic b,
                     input logic f, input logic o, input logic [3:0] idx);
    vec_t v;
    v.off = off; v.name = name; v.x = x; v.y = y; v.d = d;
    v.b = b; v.f = f; v.o = o; v.idx = idx;
    tbl.push_back(v);
  endtask

  task automatic park(input int off, input string name, input logic b,
                      input logic f, input logic [3:0] idx);
    add(off, name, 10'd0, 10'd511, 16'h0000, b, f, 1'b0, idx);
  endtask

  // Returns just after edge k, the edge at which the frame start is seen
  task automatic start_frame();
    frame_clk = 1'b0;
    step(2);
    frame_clk = 1'b1;
    step(1);
  endtask

  task automatic run_table();
    int cur;
    cur = 0;
    foreach (tbl[i]) begin
      step(tbl[i].off - cur);
      cur = tbl[i].off;
      chk(tbl[i].name, dut_pk(),
          pk(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].b, tbl[i].f, tbl[i].o, tbl[i].idx));
    end
    tbl.delete();
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) begin
      t_valid[i] = 1'b0;
      t_x[i]     = 10'd0;
      t_y[i]     = 10'd0;
      t_id[i]    = 4'd0;
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rom_mode = 0;
    watch    = 1'b0;
    fd_seen  = 1'b0;
    clear_table();

    // Reset with frame_clk already high: no frame may start on release
    reset_n   = 1'b0;
    frame_clk = 1'b1;
    step(5);
    reset_n = 1'b1;
    step(1);
    chk("rst_release", dut_pk(), pk(10'd0, 10'd511, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0));
    step(10);
    chk("rst_no_start", dut_pk(), pk(10'd0, 10'd511, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0));

    // Single sprite at (100,50), bitmap 3
    t_valid[0] = 1'b1; t_x[0] = 10'd100; t_y[0] = 10'd50; t_id[0] = 4'd3;
    park(0, "s_k0", 1'b1, 1'b0, 4'd0);
    park(3, "s_k3", 1'b1, 1'b0, 4'd0);
    add(4,    "s_first",   10'd100, 10'd50, 16'h0C00, 1'b1, 1'b0, 1'b0, 4'd0);
    add(7,    "s_hold",    10'd100, 10'd50, 16'h0C00, 1'b1, 1'b0, 1'b0, 4'd0);
    add(8,    "s_px1",     10'd101, 10'd50, 16'h0C01, 1'b1, 1'b0, 1'b0, 4'd0);
    add(132,  "s_row1",    10'd100, 10'd51, 16'h0C20, 1'b1, 1'b0, 1'b0, 4'd0);
    add(4096, "s_last",    10'd131, 10'd81, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4'd0);
    add(4098, "s_req1",    10'd131, 10'd81, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4'd1);
    add(4128, "s_done",    10'd131, 10'd81, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4'd15);
    add(4131, "s_predone", 10'd131, 10'd81, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4'd15);
    park(4132, "s_fdone", 1'b0, 1'b1, 4'd15);
    park(4133, "s_after", 1'b0, 1'b0, 4'd15);
    start_frame();
    run_table();

    // Transparency: even columns carry the colour key
    rom_mode = 1;
    park(0,  "t_k0",   1'b1, 1'b0, 4'd0);
    park(4,  "t_col0", 1'b1, 1'b0, 4'd0);
    add(8,   "t_col1", 10'd101, 10'd50, 16'h0C01, 1'b1, 1'b0, 1'b0, 4'd0);
    park(12, "t_col2", 1'b1, 1'b0, 4'd0);
    add(16,  "t_col3", 10'd103, 10'd50, 16'h0C03, 1'b1, 1'b0, 1'b0, 4'd0);
    add(4096, "t_last", 10'd131, 10'd81, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4'd0);
    park(4132, "t_fdone", 1'b0, 1'b1, 4'd15);
    start_frame();
    run_table();

    // Clipping at the bottom-right corner, bitmap 5
    rom_mode = 0;
    t_x[0] = 10'd630; t_y[0] = 10'd470; t_id[0] = 4'd5;
    add(4,    "c_origin", 10'd630, 10'd470, 16'h1400, 1'b1, 1'b0, 1'b0, 4'd0);
    add(40,   "c_col9",   10'd639, 10'd470, 16'h1409, 1'b1, 1'b0, 1'b0, 4'd0);
    park(44,  "c_col10",  1'b1, 1'b0, 4'd0);
    add(1188, "c_r9c8",   10'd638, 10'd479, 16'h1528, 1'b1, 1'b0, 1'b0, 4'd0);
    add(1192, "c_corner", 10'd639, 10'd479, 16'h1529, 1'b1, 1'b0, 1'b0, 4'd0);
    park(1196, "c_r9c10", 1'b1, 1'b0, 4'd0);
    park(1284, "c_row10", 1'b1, 1'b0, 4'd0);
    park(4096, "c_last",  1'b1, 1'b0, 4'd0);
    park(4132, "c_fdone", 1'b0, 1'b1, 4'd15);
    start_frame();
    run_table();

    // Empty table: 16 two-cycle skips, then HOLD cycles of DONE
    clear_table();
    park(0,  "e_k0",    1'b1, 1'b0, 4'd0);
    park(2,  "e_idx1",  1'b1, 1'b0, 4'd1);
    park(30, "e_idx15", 1'b1, 1'b0, 4'd15);
    park(35, "e_k35",   1'b1, 1'b0, 4'd15);
    park(36, "e_fdone", 1'b0, 1'b1, 4'd15);
    park(37, "e_after", 1'b0, 1'b0, 4'd15);
    start_frame();
    run_table();

    // Overrun: second frame edge at k+1000 aborts and restarts the walk
    t_valid[0] = 1'b1; t_x[0] = 10'd100; t_y[0] = 10'd50; t_id[0] = 4'd3;
    fd_seen = 1'b0;
    watch   = 1'b1;
    start_frame();
    step(500);
    frame_clk = 1'b0;
    step(499);
    chk("o_before", {33'd0, busy, frame_done, overrun, sprite_index},
        {33'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    frame_clk = 1'b1;
    step(1);
    chk("o_restart", {33'd0, busy, frame_done, overrun, sprite_index},
        {33'd0, 1'b1, 1'b0, 1'b1, 4'd0});
    step(4);
    chk("o_first", dut_pk(), pk(10'd100, 10'd50, 16'h0C00, 1'b1, 1'b0, 1'b1, 4'd0));
    step(4127);
    chk("o_no_early_done", {42'd0, fd_seen}, {42'd0, 1'b0});
    step(1);
    chk("o_fdone", dut_pk(), pk(10'd0, 10'd511, 16'h0, 1'b0, 1'b1, 1'b1, 4'd15));
    watch = 1'b0;

    // Reset clears the sticky overrun flag
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("o_reset_clear", dut_pk(), pk(10'd0, 10'd511, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
